// File: rtl/adc_spi_scanner_if.sv
// Pin- and sample-side signals of the ADC scanner, grouped for a single port.
// master is the scanner; slave is whatever drives the controls and models the ADC.
interface adc_spi_scanner_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 12
);
    logic              start;
    logic              scan_en;
    logic [NUM_CH-1:0] ch_mask;
    logic              sclk;
    logic              cs_n;
    logic              din;
    logic              dout;
    logic              busy;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [ADDR_W-1:0] sample_ch;

    modport master (
        input  start, scan_en, ch_mask, dout,
        output sclk, cs_n, din, busy, sample_valid, sample_data, sample_ch
    );

    modport slave (
        output start, scan_en, ch_mask, dout,
        input  sclk, cs_n, din, busy, sample_valid, sample_data, sample_ch
    );
endinterface

// File: rtl/adc_spi_scanner.sv
// SPI master that sweeps an ADC128S022-class converter over a channel mask and
// tags each returned word with the address sent one frame earlier.
module adc_spi_scanner #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned QUIET     = 8
) (
    input logic            clk,
    input logic            rst,
    adc_spi_scanner_if.master bus
);
    localparam int unsigned CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d, bit_nx;
    logic [ADDR_W-1:0] addr_q, addr_d, prev_q, prev_d, addr_sh;
    logic              prime_q, prime_d, flush_q, flush_d, scan_q, scan_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, data_q, data_d;
    logic [ADDR_W-1:0] ch_q, ch_d;
    logic              sclk_q, sclk_d, cs_n_q, cs_n_d, din_q, din_d;
    logic              busy_q, busy_d, valid_q, valid_d;
    logic [ADDR_W-1:0] lowest, next_up;
    logic              has_next, mask_any;

    assign mask_any = |bus.ch_mask;

    // Descending scan leaves the smallest qualifying index in each result.
    always_comb begin
        lowest   = '0;
        next_up  = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_mask[i]) begin
                lowest = ADDR_W'(i);
                if (i > int'(addr_q)) begin
                    next_up  = ADDR_W'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        prev_d  = prev_q;
        prime_d = prime_q;
        flush_d = flush_q;
        scan_d  = scan_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ch_d    = ch_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        din_d   = din_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bit_nx  = bit_q + 1'b1;
        addr_sh = addr_q << (bit_nx - BIT_W'(2));
        case (state_q)
            StIdle: begin
                if ((bus.start || bus.scan_en) && mask_any) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    addr_d  = lowest;
                    prime_d = 1'b1;
                    flush_d = 1'b0;
                    scan_d  = bus.scan_en;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    din_d   = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    din_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        bit_d = bit_nx;
                        din_d = (int'(bit_nx) >= 2 && int'(bit_nx) <= int'(ADDR_W) + 1) ?
                                addr_sh[ADDR_W-1] : 1'b0;
                    end else begin
                        if (int'(bit_q) >= int'(FRAME_LEN) - int'(DATA_W)) begin
                            shreg_d = {shreg_q[DATA_W-2:0], bus.dout};
                        end
                        if (int'(bit_q) == int'(FRAME_LEN) - 1) begin
                            state_d = StQuiet;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StQuiet: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    // The word just shifted in belongs to the address of the previous frame.
                    cs_n_d  = 1'b1;
                    prime_d = 1'b0;
                    if (!prime_q) begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                        ch_d    = prev_q;
                    end
                end
                if (cnt_q == CNT_W'(QUIET)) begin
                    cnt_d  = '0;
                    prev_d = addr_q;
                    if (flush_q) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StSetup;
                        cs_n_d  = 1'b0;
                        // A flush frame re-sends the current address to collect its result.
                        if (!mask_any || (scan_q && !bus.scan_en)) begin
                            flush_d = 1'b1;
                        end else if (has_next) begin
                            addr_d = next_up;
                        end else if (scan_q) begin
                            addr_d = lowest;
                        end else begin
                            flush_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            prev_q  <= '0;
            prime_q <= 1'b0;
            flush_q <= 1'b0;
            scan_q  <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            prev_q  <= prev_d;
            prime_q <= prime_d;
            flush_q <= flush_d;
            scan_q  <= scan_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sclk         = sclk_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.din          = din_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_ch    = ch_q;
endmodule

// File: tb/tb_adc_spi_scanner.sv
// Randomized bench: an ADC pin model, a per-cycle frame/sample monitor, and a
// channel-sequence model derived from the mask.
module tb_adc_spi_scanner;
    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DATA_W    = 12;
    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned QUIET     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_spi_scanner_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_spi_scanner #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FRAME_LEN(FRAME_LEN), .CLK_DIV(CLK_DIV), .QUIET(QUIET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ADC model: latches DIN on rising edges, returns the previous frame's channel value.
    logic [DATA_W-1:0] val [NUM_CH];
    logic [ADDR_W-1:0] adc_addr = '0;
    logic [ADDR_W-1:0] adc_conv = '0;
    logic [DATA_W-1:0] tx = '0;
    logic              adc_dout = 1'b0;
    int                kf = 0;
    assign bus.dout = adc_dout;

    always @(negedge bus.cs_n) begin
        kf = 0;
        adc_conv = adc_addr;
    end

    always @(negedge bus.sclk) begin
        if (bus.cs_n == 1'b0) begin
            if (kf == int'(FRAME_LEN - DATA_W)) tx = val[adc_conv];
            if (kf >= int'(FRAME_LEN - DATA_W)) begin
                adc_dout = tx[DATA_W-1];
                tx = tx << 1;
            end else begin
                adc_dout = 1'b0;
            end
            kf++;
        end
    end

    always @(posedge bus.sclk) begin
        if (bus.cs_n == 1'b0 && kf >= 3 && kf <= int'(ADDR_W) + 2)
            adc_addr = {adc_addr[ADDR_W-2:0], bus.din};
    end

    // Monitor: frame timing, and every sample tagged with the address of the frame before.
    logic [ADDR_W-1:0] frames [$];
    logic [ADDR_W-1:0] got_ch [$];
    logic [DATA_W-1:0] got_data [$];
    int                burst_frames = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              cs_prev = 1'b1;
    logic              sclk_prev = 1'b1;
    logic              frame_end;
    int                since = 0;

    always @(negedge clk) begin
        if (rst) begin
            burst_frames = 0;
            cs_prev = 1'b1;
            sclk_prev = 1'b1;
            since = 0;
        end else begin
            since++;
            frame_end = !cs_prev && bus.cs_n;
            if (!bus.busy) check("idle_pins", {30'd0, bus.cs_n, bus.sclk}, 32'd3);
            check("sample_valid", bus.sample_valid, frame_end && burst_frames > 0);
            if (bus.sample_valid) begin
                got_ch.push_back(bus.sample_ch);
                got_data.push_back(bus.sample_data);
            end
            if (frame_end) begin
                check("falls_per_frame", kf, FRAME_LEN);
                check("cs_rise_delay", since, 1);
                since = 0;
                if (burst_frames > 0) begin
                    check("sample_ch", bus.sample_ch, last_addr);
                    check("sample_data", bus.sample_data, val[last_addr]);
                end
                last_addr = adc_addr;
                frames.push_back(adc_addr);
                burst_frames++;
            end else if (cs_prev && !bus.cs_n) begin
                if (burst_frames > 0) check("quiet_len", since, QUIET);
                since = 0;
            end else if (bus.sclk != sclk_prev && !bus.cs_n) begin
                check("half_period", since, CLK_DIV);
                since = 0;
            end
            if (!bus.busy) burst_frames = 0;
            cs_prev = bus.cs_n;
            sclk_prev = bus.sclk;
        end
    end

    function automatic int nth_bit(input logic [NUM_CH-1:0] m, input int n);
        int c = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (m[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic clear_logs();
        frames.delete();
        got_ch.delete();
        got_data.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 20000) begin
            tick(1);
            n++;
        end
        check({name, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic wait_frames(input string name, input int k);
        int n = 0;
        while (frames.size() < k && n < 20000) begin
            tick(1);
            n++;
        end
        check({name, "_frames_seen"}, frames.size() >= k, 1);
    endtask

    // Ascending cyclic walk over set bits, closed by one repeated (flush) address.
    task automatic check_log(input string name, input logic [NUM_CH-1:0] m, input bit scan);
        int pc = $countones(m);
        int n = frames.size();
        if (!scan) check({name, "_nframes"}, n, pc + 1);
        for (int i = 0; i < n - 1; i++) check({name, "_addr"}, frames[i], nth_bit(m, i % pc));
        if (n >= 2) check({name, "_flush"}, frames[n-1], frames[n-2]);
        check({name, "_nsamples"}, got_ch.size(), n - 1);
    endtask

    logic [NUM_CH-1:0] m;
    bit                scan;

    initial begin
        bus.start = 1'b0;
        bus.scan_en = 1'b0;
        bus.ch_mask = '0;
        for (int i = 0; i < int'(NUM_CH); i++) val[i] = 12'hA00 | DATA_W'(i);
        tick(3);
        check("rst_cs_n", bus.cs_n, 1'b1);
        check("rst_sclk", bus.sclk, 1'b1);
        check("rst_din", bus.din, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_valid", bus.sample_valid, 1'b0);
        check("rst_data_ch", {bus.sample_data, bus.sample_ch}, '0);
        rst = 1'b0;
        tick(2);

        // Single sweep over channels 0 and 2.
        clear_logs();
        bus.ch_mask = 8'h05;
        pulse_start();
        wait_idle("m05");
        check("m05_nframes", frames.size(), 3);
        if (frames.size() == 3) begin
            check("m05_f0", frames[0], 0);
            check("m05_f1", frames[1], 2);
            check("m05_f2", frames[2], 2);
        end
        check("m05_nsamples", got_ch.size(), 2);
        if (got_ch.size() == 2) begin
            check("m05_s0", {got_ch[0], got_data[0]}, {3'd0, 12'hA00});
            check("m05_s1", {got_ch[1], got_data[1]}, {3'd2, 12'hA02});
        end

        // Address 5: DIN bits 1,0,1 decode back to 5 in the ADC model.
        clear_logs();
        bus.ch_mask = 8'h20;
        pulse_start();
        wait_idle("m20");
        check("m20_nframes", frames.size(), 2);
        if (frames.size() == 2) check("m20_addr", {frames[0], frames[1]}, {3'd5, 3'd5});
        if (got_ch.size() == 1) check("m20_s0", {got_ch[0], got_data[0]}, {3'd5, 12'hA05});
        else check("m20_nsamples", got_ch.size(), 1);

        // Reset mid-SHIFT at k=7 of the second frame.
        clear_logs();
        bus.ch_mask = 8'hFF;
        pulse_start();
        wait_frames("rst", 1);
        for (int n = 0; n < 20000 && !(kf == 8 && !bus.cs_n); n++) tick(1);
        check("rst_at_k7", kf, 8);
        rst = 1'b1;
        tick(1);
        check("midrst_pins", {28'd0, bus.cs_n, bus.sclk, bus.din, bus.busy}, 32'hC);
        check("midrst_valid", bus.sample_valid, 1'b0);
        rst = 1'b0;
        tick(300);
        check("midrst_nsamples", got_ch.size(), 0);
        check("midrst_busy", bus.busy, 1'b0);

        // Empty mask never leaves idle.
        bus.ch_mask = '0;
        bus.scan_en = 1'b1;
        pulse_start();
        for (int n = 0; n < 40; n++) begin
            check("mask0_busy_cs", {30'd0, bus.busy, bus.cs_n}, 32'd1);
            tick(1);
        end
        bus.scan_en = 1'b0;

        // start while busy is ignored.
        clear_logs();
        bus.ch_mask = 8'h01;
        pulse_start();
        tick(30);
        pulse_start();
        wait_idle("dup");
        check("dup_nframes", frames.size(), 2);
        check("dup_nsamples", got_ch.size(), 1);

        // Scan 0,1,7 twice, drop scan_en in the 7th frame.
        clear_logs();
        bus.ch_mask = 8'h83;
        bus.scan_en = 1'b1;
        pulse_start();
        wait_frames("scan", 6);
        tick(40);
        bus.scan_en = 1'b0;
        wait_idle("scan");
        check("scan_nframes", frames.size(), 8);
        check_log("scan", 8'h83, 1'b1);

        // Mask change mid-scan takes effect at the next frame boundary.
        clear_logs();
        bus.ch_mask = 8'h01;
        bus.scan_en = 1'b1;
        wait_frames("mchg", 2);
        tick(40);
        bus.ch_mask = 8'h10;
        wait_frames("mchg", 5);
        tick(40);
        bus.scan_en = 1'b0;
        wait_idle("mchg");
        check("mchg_nframes", frames.size(), 7);
        if (frames.size() == 7) check("mchg_f2_f3", {frames[2], frames[3]}, {3'd0, 3'd4});
        check("mchg_nsamples", got_ch.size(), 6);

        // Randomized masks, values and modes.
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            m = NUM_CH'($urandom_range(1, 255));
            scan = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(NUM_CH); i++) val[i] = DATA_W'($urandom);
            bus.ch_mask = m;
            if (scan) begin
                bus.scan_en = 1'b1;
                wait_frames("rnd", int'($urandom_range(1, 5)));
                tick(int'($urandom_range(0, 150)));
                bus.scan_en = 1'b0;
            end else begin
                pulse_start();
            end
            wait_idle("rnd");
            check_log("rnd", m, scan);
        end

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
